rf_wb_arbiter: RTL and testbench

//  Shares the single integer register-file write port (BUS_W path into ID_Stage) between two writeback requesters.

---
 rtl/rf_wb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: merges the unbuffered ALU result (A) with a FIFO-buffered
// load/move return (B) onto the single write port, and flags RAW hazards to decode.
module rf_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      a_valid,
    input  logic [ADDR_W-1:0]         a_addr,
    input  logic [DATA_W-1:0]         a_data,
    output logic                      a_ready,
    input  logic                      b_valid,
    input  logic [ADDR_W-1:0]         b_addr,
    input  logic [DATA_W-1:0]         b_data,
    output logic                      b_ready,
    input  logic [ADDR_W-1:0]         rs_addr,
    input  logic [ADDR_W-1:0]         rt_addr,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic                      raw_stall,
    output logic [$clog2(QDEPTH):0]   q_count
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        RR_A,
        RR_B
    } rr_e;

    logic [ADDR_W-1:0] addr_mem_q [QDEPTH];
    logic [DATA_W-1:0] data_mem_q [QDEPTH];
    logic [QDEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    rr_e               rr_last_q, rr_last_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic              empty, full;
    logic              enq, deq;
    logic              grant_a, grant_q;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              rs_fifo_hit, rt_fifo_hit;
    logic              rs_hazard, rt_hazard;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(QDEPTH));

    // No pass-through: a full FIFO refuses B even when it drains this cycle.
    assign b_ready = !full;
    assign enq     = b_valid && !full;

    always_comb begin
        grant_a = 1'b0;
        grant_q = 1'b0;
        if (a_valid && !empty) begin
            if (full || rr_last_q == RR_A) begin
                grant_q = 1'b1;
            end else begin
                grant_a = 1'b1;
            end
        end else if (a_valid) begin
            grant_a = 1'b1;
        end else if (!empty) begin
            grant_q = 1'b1;
        end
    end

    assign a_ready  = grant_a;
    assign deq      = grant_q;
    assign win_addr = grant_a ? a_addr : addr_mem_q[rd_ptr_q];
    assign win_data = grant_a ? a_data : data_mem_q[rd_ptr_q];

    always_comb begin
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (deq) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end
        if (enq) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(enq) - CW'(deq);
    end

    always_comb begin
        rr_last_d  = rr_last_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_a || grant_q) begin
            rr_last_d  = grant_a ? RR_A : RR_B;
            rf_we_d    = (win_addr != '0);
            rf_waddr_d = win_addr;
            rf_wdata_d = win_data;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem_q[wr_ptr_q] <= b_addr;
            data_mem_q[wr_ptr_q] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rr_last_q  <= RR_B;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            vld_q      <= vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rr_last_q  <= rr_last_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    always_comb begin
        rs_fifo_hit = 1'b0;
        rt_fifo_hit = 1'b0;
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            if (vld_q[i] && addr_mem_q[i] == rs_addr) rs_fifo_hit = 1'b1;
            if (vld_q[i] && addr_mem_q[i] == rt_addr) rt_fifo_hit = 1'b1;
        end
    end

    // A stalled-out ALU request and the write in flight to the RF are both uncommitted.
    assign rs_hazard = (rs_addr != '0) &&
                       (rs_fifo_hit ||
                        (a_valid && !grant_a && a_addr == rs_addr) ||
                        (rf_we_q && rf_waddr_q == rs_addr));
    assign rt_hazard = (rt_addr != '0) &&
                       (rt_fifo_hit ||
                        (a_valid && !grant_a && a_addr == rt_addr) ||
                        (rf_we_q && rf_waddr_q == rt_addr));

    assign raw_stall = rs_hazard || rt_hazard;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign q_count   = count_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_rf_wb_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned QD = 4;
    localparam int unsigned CW = $clog2(QD) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic [AW-1:0] a_addr, b_addr, rs_addr, rt_addr, rf_waddr;
    logic [DW-1:0] a_data, b_data, rf_wdata;
    logic          rf_we, raw_stall;
    logic [CW-1:0] q_count;

    int n_checks = 0;
    int n_fail   = 0;

    rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .QDEPTH(QD)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .raw_stall(raw_stall), .q_count(q_count)
    );

    always #5 clk = ~clk;

    // Reference model: pending B writes as a plain queue, who was served last, and RF port state.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           mq[$];
    bit            m_last_a;
    logic          m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    bit            p_ga, p_gq, p_bready, p_stall;

    function automatic bit m_pending(input logic [AW-1:0] x);
        if (x == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].addr == x) return 1'b1;
        if (a_valid && !p_ga && a_addr == x) return 1'b1;
        if (m_we && m_waddr == x) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_last_a = 1'b0;
        m_we     = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
        p_ga     = 1'b0;
        p_gq     = 1'b0;
    endtask

    task automatic model_predict();
        bit has_q;
        bit is_full;
        has_q   = (mq.size() > 0);
        is_full = (mq.size() == QD);
        p_ga = 1'b0;
        p_gq = 1'b0;
        if (a_valid && has_q) begin
            if (is_full || m_last_a) p_gq = 1'b1;
            else p_ga = 1'b1;
        end else if (a_valid) begin
            p_ga = 1'b1;
        end else if (has_q) begin
            p_gq = 1'b1;
        end
        p_bready = !is_full;
        p_stall  = m_pending(rs_addr) || m_pending(rt_addr);
    endtask

    task automatic model_commit();
        bit  was_full;
        wr_t w;
        was_full = (mq.size() == QD);
        if (p_ga) begin
            m_we = (a_addr != 0); m_waddr = a_addr; m_wdata = a_data; m_last_a = 1'b1;
        end else if (p_gq) begin
            w = mq.pop_front();
            m_we = (w.addr != 0); m_waddr = w.addr; m_wdata = w.data; m_last_a = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (b_valid && !was_full) mq.push_back({b_addr, b_data});
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        rs_addr = '0;   rt_addr = '0;
    endtask

    // Leaves the bench at posedge+1 with reset released and model cleared.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #12;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", rf_we); end
        n_checks++; if (rf_waddr !== '0) begin n_fail++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr); end
        n_checks++; if (rf_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
        n_checks++; if (q_count !== '0) begin n_fail++; $display("FAIL reset_qcount: got %0d want 0", q_count); end
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL reset_bready: got %0b want 1", b_ready); end
        @(posedge clk); #1 reset = 1'b1;
        model_reset();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
        @(posedge clk); #1;
        idle_inputs();
        n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL premid_we: got %0b want 1", rf_we); end
        n_checks++; if (q_count !== 3'd1) begin n_fail++; $display("FAIL premid_qcount: got %0d want 1", q_count); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL midreset_we: got %0b want 0", rf_we); end
        n_checks++; if (q_count !== '0) begin n_fail++; $display("FAIL midreset_qcount: got %0d want 0", q_count); end
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_bready: got %0b want 1", b_ready); end
        n_checks++; if (rf_wdata !== '0) begin n_fail++; $display("FAIL midreset_wdata: got %h want 0", rf_wdata); end
        @(posedge clk); #1 reset = 1'b1;
        model_reset();
    endtask

    task automatic test_a_only();
        do_reset();
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h8;
        #1;
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL aonly_ready: got %0b want 1", a_ready); end
        @(posedge clk); #1;
        a_valid = 1'b0;
        rs_addr = 5'd1;
        #1;
        n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL aonly_we: got %0b want 1", rf_we); end
        n_checks++; if (rf_waddr !== 5'd1) begin n_fail++; $display("FAIL aonly_waddr: got %0d want 1", rf_waddr); end
        n_checks++; if (rf_wdata !== 32'h8) begin n_fail++; $display("FAIL aonly_wdata: got %h want 8", rf_wdata); end
        n_checks++; if (raw_stall !== 1'b1) begin n_fail++; $display("FAIL aonly_stall_inflight: got %0b want 1", raw_stall); end
        @(posedge clk); #1;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL aonly_idle_we: got %0b want 0", rf_we); end
        n_checks++; if (rf_waddr !== 5'd1) begin n_fail++; $display("FAIL aonly_hold_waddr: got %0d want 1", rf_waddr); end
        n_checks++; if (raw_stall !== 1'b0) begin n_fail++; $display("FAIL aonly_stall_clear: got %0b want 0", raw_stall); end
        rs_addr = '0;
    endtask

    task automatic test_contention();
        logic [AW-1:0] exp_addr [4];
        logic [DW-1:0] exp_data [4];
        logic [CW-1:0] exp_cnt  [4];
        exp_addr = '{5'd20, 5'd2, 5'd22, 5'd11};
        exp_data = '{32'h0, 32'h10, 32'h2, 32'h11};
        exp_cnt  = '{3'd2, 3'd1, 3'd1, 3'd0};
        do_reset();
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h10;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            a_valid = 1'b1; a_addr = AW'(20 + k); a_data = DW'(k);
            b_valid = (k == 0); b_addr = 5'd11; b_data = 32'h11;
            #1;
            n_checks++;
            if (a_ready !== ((k % 2) == 0)) begin
                n_fail++; $display("FAIL contention_grant[%0d]: a_ready got %0b want %0b", k, a_ready, (k % 2) == 0);
            end
            @(posedge clk); #1;
            n_checks++;
            if (rf_waddr !== exp_addr[k] || rf_wdata !== exp_data[k] || rf_we !== 1'b1) begin
                n_fail++; $display("FAIL contention_commit[%0d]: got we=%0b r%0d=%h want we=1 r%0d=%h",
                                   k, rf_we, rf_waddr, rf_wdata, exp_addr[k], exp_data[k]);
            end
            n_checks++;
            if (q_count !== exp_cnt[k]) begin
                n_fail++; $display("FAIL contention_qcount[%0d]: got %0d want %0d", k, q_count, exp_cnt[k]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_full();
        int n_a = 0;
        int n_b = 0;
        bit seen_full = 1'b0;
        do_reset();
        a_valid = 1'b1; a_addr = 5'd8; a_data = 32'hA0;
        for (int c = 0; c < 24; c++) begin
            b_valid = 1'b1; b_addr = AW'(3 + (n_b % 4)); b_data = DW'(32'hB0 + n_b);
            #1;
            model_predict();
            n_checks++; if (a_ready !== p_ga) begin n_fail++; $display("FAIL full_aready[%0d]: got %0b want %0b", c, a_ready, p_ga); end
            n_checks++; if (b_ready !== p_bready) begin n_fail++; $display("FAIL full_bready[%0d]: got %0b want %0b", c, b_ready, p_bready); end
            if (q_count == CW'(QD)) begin
                seen_full = 1'b1;
                n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL full_forced_drain[%0d]: a_ready got %0b want 0", c, a_ready); end
                n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_accept[%0d]: b_ready got %0b want 0", c, b_ready); end
            end
            @(posedge clk);
            model_commit();
            if (b_ready) n_b++;
            #1;
            n_checks++;
            if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
                n_fail++; $display("FAIL full_commit[%0d]: got we=%0b r%0d=%h want we=%0b r%0d=%h",
                                   c, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
            end
            n_checks++; if (q_count !== CW'(mq.size())) begin n_fail++; $display("FAIL full_qcount[%0d]: got %0d want %0d", c, q_count, mq.size()); end
            if (p_ga) begin
                n_a++;
                a_addr = (n_a == 4) ? 5'd7 : AW'(8 + n_a); a_data = DW'(32'hA0 + n_a);
            end
        end
        n_checks++; if (seen_full !== 1'b1) begin n_fail++; $display("FAIL full_reached: got %0b want 1", seen_full); end
        idle_inputs();
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
        end
        #1;
        n_checks++; if (q_count !== '0) begin n_fail++; $display("FAIL full_drained: got %0d want 0", q_count); end
        model_reset();
    endtask

    task automatic test_r0();
        do_reset();
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        idle_inputs();
        #1;
        n_checks++; if (q_count !== 3'd1) begin n_fail++; $display("FAIL r0_queued: got %0d want 1", q_count); end
        n_checks++; if (raw_stall !== 1'b0) begin n_fail++; $display("FAIL r0_nostall: got %0b want 0", raw_stall); end
        @(posedge clk); #1;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL r0_we: got %0b want 0", rf_we); end
        n_checks++; if (q_count !== '0) begin n_fail++; $display("FAIL r0_dequeued: got %0d want 0", q_count); end
        n_checks++; if (rf_wdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL r0_wdata: got %h want ffffffff", rf_wdata); end
    endtask

    task automatic test_hazard();
        do_reset();
        b_valid = 1'b1; b_addr = 5'd5; b_data = 32'h55;
        rs_addr = 5'd5;
        #1;
        n_checks++; if (raw_stall !== 1'b0) begin n_fail++; $display("FAIL hz_before_enq: got %0b want 0", raw_stall); end
        @(posedge clk); #1;
        b_valid = 1'b0;
        #1;
        n_checks++; if (raw_stall !== 1'b1) begin n_fail++; $display("FAIL hz_fifo: got %0b want 1", raw_stall); end
        @(posedge clk); #1;
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5) begin n_fail++; $display("FAIL hz_commit: got we=%0b r%0d want we=1 r5", rf_we, rf_waddr); end
        n_checks++; if (raw_stall !== 1'b1) begin n_fail++; $display("FAIL hz_inflight: got %0b want 1", raw_stall); end
        @(posedge clk); #1;
        n_checks++; if (raw_stall !== 1'b0) begin n_fail++; $display("FAIL hz_cleared: got %0b want 0", raw_stall); end
        rs_addr = '0; rt_addr = 5'd6;
        b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h66;
        @(posedge clk); #1;
        b_valid = 1'b0;
        #1;
        n_checks++; if (raw_stall !== 1'b1) begin n_fail++; $display("FAIL hz_rt_fifo: got %0b want 1", raw_stall); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (raw_stall !== 1'b0) begin n_fail++; $display("FAIL hz_rt_cleared: got %0b want 0", raw_stall); end
        idle_inputs();
    endtask

    task automatic test_random();
        int b_pct;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (!a_valid || p_ga) begin
                a_valid = ($urandom_range(0, 99) < 60);
                a_addr  = AW'($urandom_range(0, 7));
                a_data  = $urandom;
            end
            b_pct   = ((c / 250) % 2 == 0) ? 85 : 30;
            b_valid = ($urandom_range(0, 99) < b_pct);
            b_addr  = AW'($urandom_range(0, 7));
            b_data  = $urandom;
            rs_addr = AW'($urandom_range(0, 7));
            rt_addr = AW'($urandom_range(0, 7));
            #1;
            model_predict();
            n_checks++; if (a_ready !== p_ga) begin n_fail++; $display("FAIL rnd_aready[%0d]: got %0b want %0b", c, a_ready, p_ga); end
            n_checks++; if (b_ready !== p_bready) begin n_fail++; $display("FAIL rnd_bready[%0d]: got %0b want %0b", c, b_ready, p_bready); end
            n_checks++; if (raw_stall !== p_stall) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %0b want %0b", c, raw_stall, p_stall); end
            @(posedge clk);
            model_commit();
            #1;
            n_checks++;
            if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
                n_fail++; $display("FAIL rnd_commit[%0d]: got we=%0b r%0d=%h want we=%0b r%0d=%h",
                                   c, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
            end
            n_checks++; if (q_count !== CW'(mq.size())) begin n_fail++; $display("FAIL rnd_qcount[%0d]: got %0d want %0d", c, q_count, mq.size()); end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_a_only();
        test_contention();
        test_full();
        test_r0();
        test_hazard();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
